ender_rtc_calendar: RTL
=======================

# ender_rtc_calendar

Parametrised real-time clock/calendar core for the next generation of the ender clock. It keeps seconds, minutes, hours, day, month and year with leap-year-aware month lengths, and provides per-field increment/decrement editing and an hour:minute alarm. The core sits between the debounced key strobes and the segment display mux. It replaces the fixed seconds/minutes/hours/day/month counter chain with one block.

## Interface
Parameters:
- TICK_DIV, 32768: clock cycles per second; must be at least 2.
- YEAR_MAX, 99: highest year offset from 2000. Leap rule is year%4==0, valid for 2000–2099.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler advances; 0 = time frozen, edits still allowed.
- sel  in  3  edit field: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 alarm hour, 7 alarm min.
- inc  in  1  one-cycle strobe: +1 on the selected field.
- dec  in  1  one-cycle strobe: −1 on the selected field.
- alarm_en  in  1  enables alarm_hit.
- sec  out  6  0–59.
- min  out  6  0–59.
- hour  out  5  0–23.
- day  out  5  1–days_in_month.
- month  out  4  1–12.
- year  out  7  0–YEAR_MAX.
- alarm_hour  out  5  0–23.
- alarm_min  out  6  0–59.
- sec_pulse  out  1  one-cycle pulse on every tick-driven second update.
- alarm_hit  out  1  one-cycle alarm pulse.
- half_sec  out  1  high while prescaler < TICK_DIV/2; used for colon blink.

## Operation
- Reset values: prescaler 0, pending 0, sec/min/hour 0, day 1, month 1, year 0, alarm 00:00, sec_pulse 0, alarm_hit 0.
- Prescaler: counts 0..TICK_DIV−1 while run=1, then wraps to 0. While run=0 it holds.
- A tick is the cycle in which the prescaler equals TICK_DIV−1 and run=1.
- Tick carry chain: sec 59→0 carries into min; min 59→0 into hour; hour 23→0 into day; day==days_in_month→1 into month; month 12→1 into year; year YEAR_MAX→0.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11. February is 29 when year%4==0, else 28.
- Editing:
  - inc or dec changes only the selected field and wraps within that field's range. There is never a carry into neighbouring fields.
  - Day wraps within 1..days_in_month for the current month and year.
  - inc and dec high in the same cycle: no change.
  - Any edit of sec (sel=0) also clears the prescaler to 0.
- Day clamp: after a month or year edit, if day > new days_in_month, day becomes days_in_month in the same update.
- Tick/edit collision: if inc or dec is accepted in a tick cycle, the tick is not applied. A pending flag is set instead, and the deferred tick is applied on the next cycle without an accepted edit. sec_pulse and alarm_hit follow the deferred update.
- Alarm: alarm_hit=1 when a tick-driven update produces hour==alarm_hour, min==alarm_min, sec==0 with alarm_en=1.
  - Edits never raise alarm_hit.
  - Alarm fields are edited with sel 6/7 and wrap like hour/min.

## Timing
- All outputs are registered. The update from a tick is visible on the clock edge that ends the tick cycle, and sec_pulse is high for exactly that following cycle.
- An edit is visible one cycle after the strobe cycle.
- alarm_hit is coincident with the sec_pulse of the matching update.
- reset asserted mid-operation: all state returns to reset values on the next edge, including the pending flag. reset has priority over run/inc/dec.
- half_sec is a registered compare of the prescaler and changes one cycle after the prescaler crosses TICK_DIV/2.

## Test plan
All scenarios use TICK_DIV=4 and YEAR_MAX=99.
- Full rollover: preset 23:59:59, 12/31, year 99, run=1 → after one tick: 00:00:00, 1/1, year 0, with a single sec_pulse.
- Leap year:
  - 23:59:59, 2/28, year 4 → 2/29 after the tick.
  - Same time and date with year 5 → 3/1.
- Clamp and wrap:
  - day 31, month 1, year 1, inc with sel=4 → month 2, day 28.
  - sec 0, dec with sel=0 → sec 59, min unchanged, prescaler 0.
- Alarm:
  - alarm 07:30, alarm_en=1, time 07:29:59 → alarm_hit pulses once with 07:30:00.
  - Repeat with alarm_en=0 → no pulse.
  - Edit min to 30 with sec=0 → no pulse.
- Collision: inc on sel=1 in a tick cycle at 10:10:10 → next cycle 10:11:10, then the following cycle 10:11:11 with sec_pulse. No second is lost.
- Reset mid-run: assert reset with pending set and prescaler 2 → next cycle 00:00:00, 1/1, year 0. No deferred tick fires afterwards.

Source files
------------

// File: rtl/ender_rtc_calendar.sv
// Real-time clock/calendar: prescaled seconds tick with a leap-aware carry chain,
// per-field inc/dec editing with day clamping, deferred ticks on edit collision, and an hh:mm alarm.
module ender_rtc_calendar #(
  parameter int TICK_DIV = 32768,
  parameter int YEAR_MAX = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       alarm_en,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       sec_pulse,
  output logic       alarm_hit,
  output logic       half_sec
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);
  localparam logic [6:0]    YMAX     = 7'(YEAR_MAX);

  logic [PW-1:0] pre_q, pre_d;
  logic          pend_q, pend_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d, amin_q, amin_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d, ahour_q, ahour_d;
  logic [3:0]    month_q, month_d;
  logic [6:0]    year_q, year_d;
  logic          pulse_q, pulse_d, hit_q, hit_d, half_q, half_d;

  logic          tick, edit, do_tick;
  logic [4:0]    dim_cur, dim_new;
  logic [3:0]    month_new;
  logic [6:0]    year_new;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  always_comb begin
    pre_d     = pre_q;
    pend_d    = pend_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    month_d   = month_q;
    year_d    = year_q;
    ahour_d   = ahour_q;
    amin_d    = amin_q;
    month_new = month_q;
    year_new  = year_q;
    dim_new   = 5'd31;
    dim_cur   = days_in_month(month_q, year_q);

    // inc and dec together cancel and do not count as an edit
    tick    = run && (pre_q == PRE_LAST);
    edit    = inc ^ dec;
    do_tick = (tick || pend_q) && !edit;
    pend_d  = (tick || pend_q) && edit;

    if (edit && (sel == 3'd0))
      pre_d = '0;
    else if (run)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);

    if (do_tick) begin
      if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
      else begin
        sec_d = 6'd0;
        if (min_q != 6'd59) min_d = min_q + 6'd1;
        else begin
          min_d = 6'd0;
          if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
          else begin
            hour_d = 5'd0;
            if (day_q != dim_cur) day_d = day_q + 5'd1;
            else begin
              day_d = 5'd1;
              if (month_q != 4'd12) month_d = month_q + 4'd1;
              else begin
                month_d = 4'd1;
                year_d  = (year_q == YMAX) ? 7'd0 : year_q + 7'd1;
              end
            end
          end
        end
      end
    end else if (edit) begin
      case (sel)
        3'd0: sec_d = inc ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                          : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
        3'd1: min_d = inc ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                          : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
        3'd2: hour_d = inc ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                           : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
        3'd3: day_d = inc ? ((day_q >= dim_cur) ? 5'd1 : day_q + 5'd1)
                          : ((day_q <= 5'd1) ? dim_cur : day_q - 5'd1);
        3'd4: begin
          month_new = inc ? ((month_q == 4'd12) ? 4'd1 : month_q + 4'd1)
                          : ((month_q == 4'd1) ? 4'd12 : month_q - 4'd1);
          dim_new   = days_in_month(month_new, year_q);
          month_d   = month_new;
          if (day_q > dim_new) day_d = dim_new;
        end
        3'd5: begin
          year_new = inc ? ((year_q == YMAX) ? 7'd0 : year_q + 7'd1)
                         : ((year_q == 7'd0) ? YMAX : year_q - 7'd1);
          dim_new  = days_in_month(month_q, year_new);
          year_d   = year_new;
          if (day_q > dim_new) day_d = dim_new;
        end
        3'd6: ahour_d = inc ? ((ahour_q == 5'd23) ? 5'd0 : ahour_q + 5'd1)
                            : ((ahour_q == 5'd0) ? 5'd23 : ahour_q - 5'd1);
        default: amin_d = inc ? ((amin_q == 6'd59) ? 6'd0 : amin_q + 6'd1)
                              : ((amin_q == 6'd0) ? 6'd59 : amin_q - 6'd1);
      endcase
    end

    pulse_d = do_tick;
    hit_d   = do_tick && alarm_en && (hour_d == ahour_q) && (min_d == amin_q) && (sec_d == 6'd0);
    half_d  = (pre_q < PRE_HALF);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q   <= '0;
      pend_q  <= 1'b0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 7'd0;
      ahour_q <= 5'd0;
      amin_q  <= 6'd0;
      pulse_q <= 1'b0;
      hit_q   <= 1'b0;
      half_q  <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      ahour_q <= ahour_d;
      amin_q  <= amin_d;
      pulse_q <= pulse_d;
      hit_q   <= hit_d;
      half_q  <= half_d;
    end
  end

  assign sec        = sec_q;
  assign min        = min_q;
  assign hour       = hour_q;
  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign alarm_hour = ahour_q;
  assign alarm_min  = amin_q;
  assign sec_pulse  = pulse_q;
  assign alarm_hit  = hit_q;
  assign half_sec   = half_q;

endmodule
